// File: rtl/puck_setpoint_gen.sv
// ---------------------------------------------------------------------------
// puck_setpoint_gen
//
// Turns per-frame puck pixel coordinates into a conditioned 32-bit encoder
// count setpoint for the motor controller's puck-detection input.
// Processing chain: input capture -> scale (S1) -> offset + clamp (S2) ->
// moving average window (S3) -> rate limit into SET_POS_PD (S4).
// A sample captured at edge k updates SET_POS_PD at edge k+4.
// A watchdog homes the setpoint when no puck has been found for TIMEOUT
// cycles while tracking.
//
// Ports:
//   CLK100MHZ      system clock
//   resetn         asynchronous active-low reset
//   ENABLE         1 = track the puck, 0 = hold HOME_POS
//   PIX_X          puck coordinate along the motor axis
//   PIX_VALID      one-cycle strobe per processed frame
//   PIX_FOUND      qualifies PIX_VALID: puck present in the frame
//   SET_POS_PD     conditioned setpoint (unsigned counts)
//   SET_POS_VALID  one-cycle pulse on every SET_POS_PD update
//   TRACKING       high while in the TRACK state
//   TIMED_OUT      sticky watchdog flag, cleared by the next accepted sample
// ---------------------------------------------------------------------------
module puck_setpoint_gen #(
  parameter int                 PIX_W    = 11,
  parameter logic [15:0]        SCALE    = 16'd2560,
  parameter logic signed [31:0] OFFSET   = 32'sd0,
  parameter int                 POS_MIN  = 200,
  parameter int                 POS_MAX  = 20000,
  parameter int                 HOME_POS = 1000,
  parameter int                 MAX_STEP = 500,
  parameter int                 AVG_LOG2 = 2,
  parameter int                 TIMEOUT  = 5000000
) (
  input  logic             CLK100MHZ,
  input  logic             resetn,
  input  logic             ENABLE,
  input  logic [PIX_W-1:0] PIX_X,
  input  logic             PIX_VALID,
  input  logic             PIX_FOUND,
  output logic [31:0]      SET_POS_PD,
  output logic             SET_POS_VALID,
  output logic             TRACKING,
  output logic             TIMED_OUT
);

  localparam int WIN    = 1 << AVG_LOG2;
  localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PROD_W = PIX_W + 16;
  localparam int SUM_W  = 32 + AVG_LOG2;
  localparam int CNT_W  = $clog2(TIMEOUT);

  localparam logic signed [33:0] MIN_S  = 34'(POS_MIN);
  localparam logic signed [33:0] MAX_S  = 34'(POS_MAX);
  localparam logic signed [32:0] STEP_S = 33'(MAX_STEP);
  localparam logic [31:0]        MIN_U  = 32'(POS_MIN);
  localparam logic [31:0]        MAX_U  = 32'(POS_MAX);
  localparam logic [31:0]        HOME_U = 32'(HOME_POS);
  localparam logic [31:0]        STEP_U = 32'(MAX_STEP);

  typedef enum logic {
    ST_HOME,
    ST_TRACK
  } state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             expire;
  logic             flush;
  logic [CNT_W-1:0] wd_cnt;

  // Pipeline stage registers with their valid bits.
  logic              v0, v1, v2, v3;
  logic [PIX_W-1:0]  pix0;
  logic [PROD_W-1:0] prod1;
  logic [31:0]       samp2;
  logic [SUM_W-1:0]  sum3;

  logic signed [33:0] s_wide;
  logic [31:0]        s_clamped;

  // Moving-average window.
  logic [31:0]      win [WIN];
  logic [PTR_W-1:0] ptr;
  logic             win_empty;
  logic             win_fill;
  logic             win_shift;

  logic [31:0]        avg;
  logic signed [32:0] delta;

  assign accept = PIX_VALID & PIX_FOUND & ENABLE;

  // An accepted sample on the expiry edge wins: it restarts the watchdog.
  assign expire = ENABLE & (state == ST_TRACK) &
                  (wd_cnt == CNT_W'(TIMEOUT - 1)) & ~accept;

  // Disable drops everything in flight; expiry only ever finds the pipe
  // empty (TIMEOUT is far longer than the pipe) but must empty the window.
  assign flush = ~ENABLE | expire;

  assign TRACKING = (state == ST_TRACK);

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      state <= ST_HOME;
    end else begin
      // NOTE: clocked state uses non-blocking (<=) so every flop samples the
      // pre-edge values; blocking here would create order-dependent races.
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: assigning the default first means every path drives state_nxt,
    // so no latch is inferred when a case arm leaves it untouched.
    state_nxt = state;
    case (state)
      ST_HOME:  if (accept) state_nxt = ST_TRACK;
      ST_TRACK: if (!ENABLE || expire) state_nxt = ST_HOME;
      default:  state_nxt = ST_HOME;
    endcase
  end

  // -------------------------------------------------------------------------
  // Watchdog and sticky timeout flag
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      wd_cnt    <= '0;
      TIMED_OUT <= 1'b0;
    end else begin
      if (accept || expire || !ENABLE || state != ST_TRACK) wd_cnt <= '0;
      else                                                  wd_cnt <= wd_cnt + 1'b1;

      if (accept)      TIMED_OUT <= 1'b0;
      else if (expire) TIMED_OUT <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Capture, scale (S1), offset + clamp (S2)
  // -------------------------------------------------------------------------
  // Drop the Q8.8 fraction, then add the signed offset with headroom so a
  // negative result or a large product still compares correctly.
  assign s_wide = $signed({{(34 - (PROD_W - 8)){1'b0}}, prod1[PROD_W-1:8]}) +
                  $signed({{2{OFFSET[31]}}, OFFSET});

  always_comb begin
    s_clamped = s_wide[31:0];
    if (s_wide < MIN_S)      s_clamped = MIN_U;
    else if (s_wide > MAX_S) s_clamped = MAX_U;
  end

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      v0    <= 1'b0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      pix0  <= '0;
      prod1 <= '0;
      samp2 <= '0;
    end else begin
      pix0  <= PIX_X;
      prod1 <= PROD_W'(pix0) * PROD_W'(SCALE);
      samp2 <= s_clamped;
      if (flush) begin
        v0 <= 1'b0;
        v1 <= 1'b0;
        v2 <= 1'b0;
      end else begin
        v0 <= accept;
        v1 <= v0;
        v2 <= v1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Moving-average window (S3)
  // -------------------------------------------------------------------------
  // First sample after an empty window prefills every slot, so the average
  // starts at the sample instead of ramping up from stale data.
  assign win_fill  = v2 & win_empty & ~flush;
  assign win_shift = v2 & ~win_empty & ~flush;

  // NOTE: the window storage has no reset; win_empty guarantees it is
  // overwritten before any entry is read, so resetting it buys nothing.
  always_ff @(posedge CLK100MHZ) begin
    if (win_fill) begin
      for (int i = 0; i < WIN; i++) win[i] <= samp2;
    end else if (win_shift) begin
      win[ptr] <= samp2;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      win_empty <= 1'b1;
      ptr       <= '0;
      sum3      <= '0;
      v3        <= 1'b0;
    end else if (flush) begin
      win_empty <= 1'b1;
      v3        <= 1'b0;
    end else begin
      v3 <= v2;
      if (win_fill) begin
        sum3      <= SUM_W'(samp2) << AVG_LOG2;
        ptr       <= '0;
        win_empty <= 1'b0;
      end else if (win_shift) begin
        // Running sum: add the newcomer, retire the oldest slot.
        sum3 <= sum3 + SUM_W'(samp2) - SUM_W'(win[ptr]);
        ptr  <= (ptr == PTR_W'(WIN - 1)) ? '0 : ptr + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Average + rate limit into the output register (S4)
  // -------------------------------------------------------------------------
  assign avg   = sum3[SUM_W-1:AVG_LOG2];
  assign delta = $signed({1'b0, avg}) - $signed({1'b0, SET_POS_PD});

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      SET_POS_PD    <= HOME_U;
      SET_POS_VALID <= 1'b0;
    end else if (!ENABLE) begin
      // Homing beats any pending S4 result; pulse only if the value moves.
      SET_POS_VALID <= (SET_POS_PD != HOME_U);
      SET_POS_PD    <= HOME_U;
    end else if (expire) begin
      SET_POS_VALID <= 1'b1;
      SET_POS_PD    <= HOME_U;
    end else if (v3) begin
      SET_POS_VALID <= 1'b1;
      if (delta > STEP_S)       SET_POS_PD <= SET_POS_PD + STEP_U;
      else if (delta < -STEP_S) SET_POS_PD <= SET_POS_PD - STEP_U;
      else                      SET_POS_PD <= avg;
    end else begin
      SET_POS_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_puck_setpoint_gen.sv
// ---------------------------------------------------------------------------
// tb_puck_setpoint_gen
//
// Scoreboard bench for puck_setpoint_gen. Every accepted sample is run
// through a behavioural model (window kept as an explicit array and averaged
// directly) and the expected setpoint is queued with the cycle it is due.
// A monitor on the falling edge pops and compares each SET_POS_VALID pulse,
// and flags pulses that are unexpected, early, late or missing.
// The DUT is built with a short watchdog so expiry is reachable.
// ---------------------------------------------------------------------------
module tb_puck_setpoint_gen;

  localparam int PIX_W    = 11;
  localparam int SCALE    = 2560;
  localparam int OFFSET   = 0;
  localparam int POS_MIN  = 200;
  localparam int POS_MAX  = 20000;
  localparam int HOME_POS = 1000;
  localparam int MAX_STEP = 500;
  localparam int AVG_LOG2 = 2;
  localparam int WIN      = 1 << AVG_LOG2;
  localparam int TIMEOUT  = 1000;

  logic             CLK100MHZ = 1'b0;
  logic             resetn    = 1'b0;
  logic             ENABLE    = 1'b0;
  logic [PIX_W-1:0] PIX_X     = '0;
  logic             PIX_VALID = 1'b0;
  logic             PIX_FOUND = 1'b0;
  logic [31:0]      SET_POS_PD;
  logic             SET_POS_VALID;
  logic             TRACKING;
  logic             TIMED_OUT;

  puck_setpoint_gen #(
    .PIX_W   (PIX_W),
    .SCALE   (16'(SCALE)),
    .OFFSET  (32'(OFFSET)),
    .POS_MIN (POS_MIN),
    .POS_MAX (POS_MAX),
    .HOME_POS(HOME_POS),
    .MAX_STEP(MAX_STEP),
    .AVG_LOG2(AVG_LOG2),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK100MHZ    (CLK100MHZ),
    .resetn       (resetn),
    .ENABLE       (ENABLE),
    .PIX_X        (PIX_X),
    .PIX_VALID    (PIX_VALID),
    .PIX_FOUND    (PIX_FOUND),
    .SET_POS_PD   (SET_POS_PD),
    .SET_POS_VALID(SET_POS_VALID),
    .TRACKING     (TRACKING),
    .TIMED_OUT    (TIMED_OUT)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int cyc = 0;  // rising edges seen so far
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t q[$];
  int   mon_last  = HOME_POS;
  int   last_send = 0;

  // Behavioural model state.
  longint mdl_win [WIN];
  int     mdl_ptr   = 0;
  bit     mdl_empty = 1'b1;
  longint mdl_pos   = HOME_POS;

  // -------------------------------------------------------------------------
  // Monitor: every pulse must match the queue head on its due cycle.
  // -------------------------------------------------------------------------
  always @(negedge CLK100MHZ) begin
    if (resetn) begin
      if (SET_POS_VALID) begin
        checks++;
        if (q.size() == 0 || q[0].due != cyc) begin
          failures++;
          $display("FAIL pulse_unexpected: pulse at cycle %0d value %0d, required no pulse (next due %0d)",
                   cyc, SET_POS_PD, (q.size() > 0) ? q[0].due : -1);
        end else begin
          if (SET_POS_PD !== q[0].val) begin
            failures++;
            $display("FAIL setpoint_value: cycle %0d got %0d, required %0d", cyc, SET_POS_PD, q[0].val);
          end
          mon_last = q[0].val;
          q.delete(0);
        end
        checks++;
        if (SET_POS_PD < POS_MIN || SET_POS_PD > POS_MAX) begin
          failures++;
          $display("FAIL setpoint_range: cycle %0d got %0d, required %0d..%0d", cyc, SET_POS_PD, POS_MIN, POS_MAX);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        checks++;
        failures++;
        $display("FAIL pulse_missing: cycle %0d got no pulse, required value %0d due at %0d", cyc, q[0].val, q[0].due);
        mon_last = q[0].val;
        q.delete(0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: simulation still running at %0t, required completion", $time);
    $fatal(1, "simulation time limit");
  end

  // -------------------------------------------------------------------------
  // Helpers (all start and end on a falling edge)
  // -------------------------------------------------------------------------
  task automatic tick();
    @(negedge CLK100MHZ);
  endtask

  task automatic model_sample(input int px, output logic [31:0] v);
    longint s, acc, avg, delta;
    s = ((longint'(px) * SCALE) >>> 8) + OFFSET;
    if (s < POS_MIN) s = POS_MIN;
    if (s > POS_MAX) s = POS_MAX;
    if (mdl_empty) begin
      for (int i = 0; i < WIN; i++) mdl_win[i] = s;
      mdl_ptr   = 0;
      mdl_empty = 1'b0;
    end else begin
      mdl_win[mdl_ptr] = s;
      mdl_ptr = (mdl_ptr + 1) % WIN;
    end
    acc = 0;
    for (int i = 0; i < WIN; i++) acc += mdl_win[i];
    avg   = acc / WIN;
    delta = avg - mdl_pos;
    if (delta > MAX_STEP)       mdl_pos = mdl_pos + MAX_STEP;
    else if (delta < -MAX_STEP) mdl_pos = mdl_pos - MAX_STEP;
    else                        mdl_pos = avg;
    v = 32'(mdl_pos);
  endtask

  task automatic send(input int px, input bit found);
    logic [31:0] v;
    PIX_X     = 11'(px);
    PIX_VALID = 1'b1;
    PIX_FOUND = found;
    if (ENABLE && found) begin
      model_sample(px, v);
      q.push_back('{val: v, due: cyc + 5});
      last_send = cyc;
    end
    tick();
    PIX_VALID = 1'b0;
    PIX_FOUND = 1'b0;
  endtask

  task automatic set_enable(input bit en);
    int pos;
    if (!en && ENABLE) begin
      // Results due after the next edge are discarded by the homing action.
      while (q.size() > 0 && q[$].due > cyc) q.delete(q.size() - 1);
      pos = (q.size() > 0) ? int'(q[$].val) : mon_last;
      if (pos != HOME_POS) q.push_back('{val: 32'(HOME_POS), due: cyc + 1});
      mdl_pos   = HOME_POS;
      mdl_empty = 1'b1;
    end
    ENABLE = en;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && q.size() > 0; i++) tick();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d results still outstanding, required 0", q.size());
    end
  endtask

  task automatic go_home();
    set_enable(1'b0);
    repeat (3) tick();
    set_enable(1'b1);
    tick();
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    int pulses;
    resetn = 1'b0;
    repeat (3) tick();
    checks += 4;
    if (SET_POS_PD !== 32'(HOME_POS)) begin failures++; $display("FAIL reset_pos: got %0d, required %0d", SET_POS_PD, HOME_POS); end
    if (SET_POS_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, required 0", SET_POS_VALID); end
    if (TRACKING !== 1'b0) begin failures++; $display("FAIL reset_tracking: got %b, required 0", TRACKING); end
    if (TIMED_OUT !== 1'b0) begin failures++; $display("FAIL reset_timed_out: got %b, required 0", TIMED_OUT); end
    resetn = 1'b1;
    // ENABLE low for 100 cycles, with frames arriving that must be ignored.
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      if (SET_POS_VALID) pulses++;
      if (i % 10 == 0) send(400, 1'b1);
      else             tick();
    end
    checks += 2;
    if (pulses != 0) begin failures++; $display("FAIL disabled_pulses: got %0d, required 0", pulses); end
    if (TRACKING !== 1'b0) begin failures++; $display("FAIL disabled_tracking: got %b, required 0", TRACKING); end
    // Enabled but puck not found: still ignored.
    set_enable(1'b1);
    send(400, 1'b0);
    repeat (6) tick();
    checks++;
    if (TRACKING !== 1'b0) begin failures++; $display("FAIL notfound_tracking: got %b, required 0", TRACKING); end
  endtask

  task automatic test_track_step();
    send(400, 1'b1);
    checks++;
    if (TRACKING !== 1'b1) begin failures++; $display("FAIL track_enter: got %b, required 1", TRACKING); end
    repeat (5) send(400, 1'b1);
    drain();
    checks++;
    if (SET_POS_PD !== 32'd4000) begin failures++; $display("FAIL track_final: got %0d, required 4000", SET_POS_PD); end
  endtask

  task automatic test_averaging();
    repeat (4) send(440, 1'b1);
    drain();
    checks++;
    if (SET_POS_PD !== 32'd4400) begin failures++; $display("FAIL avg_final: got %0d, required 4400", SET_POS_PD); end
  endtask

  task automatic test_clamp();
    go_home();
    repeat (2) send(0, 1'b1);
    drain();
    checks++;
    if (SET_POS_PD !== 32'd200) begin failures++; $display("FAIL clamp_low: got %0d, required 200", SET_POS_PD); end
    repeat (45) send(2047, 1'b1);
    drain();
    checks++;
    if (SET_POS_PD !== 32'd20000) begin failures++; $display("FAIL clamp_high: got %0d, required 20000", SET_POS_PD); end
  endtask

  task automatic test_watchdog();
    int c;
    go_home();
    repeat (6) send(400, 1'b1);
    drain();
    // Sample on the very edge the watchdog would expire: the sample wins.
    c = last_send;
    while (cyc < c + TIMEOUT) tick();
    send(400, 1'b1);
    // Now let it expire, TIMEOUT edges after the last accepted edge.
    c = last_send;
    while (cyc < c + TIMEOUT) tick();
    checks += 2;
    if (TRACKING !== 1'b1) begin failures++; $display("FAIL wd_before_tracking: got %b, required 1", TRACKING); end
    if (TIMED_OUT !== 1'b0) begin failures++; $display("FAIL wd_before_flag: got %b, required 0", TIMED_OUT); end
    q.push_back('{val: 32'(HOME_POS), due: c + TIMEOUT + 1});
    mdl_pos   = HOME_POS;
    mdl_empty = 1'b1;
    tick();
    checks += 3;
    if (TIMED_OUT !== 1'b1) begin failures++; $display("FAIL wd_flag: got %b, required 1", TIMED_OUT); end
    if (TRACKING !== 1'b0) begin failures++; $display("FAIL wd_tracking: got %b, required 0", TRACKING); end
    if (SET_POS_PD !== 32'(HOME_POS)) begin failures++; $display("FAIL wd_pos: got %0d, required %0d", SET_POS_PD, HOME_POS); end
    send(400, 1'b1);
    checks += 2;
    if (TIMED_OUT !== 1'b0) begin failures++; $display("FAIL wd_clear: got %b, required 0", TIMED_OUT); end
    if (TRACKING !== 1'b1) begin failures++; $display("FAIL wd_retrack: got %b, required 1", TRACKING); end
    drain();
    checks++;
    if (SET_POS_PD !== 32'd1500) begin failures++; $display("FAIL wd_refill: got %0d, required 1500", SET_POS_PD); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    send(400, 1'b1);
    send(401, 1'b1);
    send(402, 1'b1);
    repeat (2) tick();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (SET_POS_VALID) pulses++;
      if (i < 2) tick();
    end
    checks += 2;
    if (pulses != 3) begin failures++; $display("FAIL b2b_pulses: got %0d, required 3", pulses); end
    if (SET_POS_PD !== 32'd3000) begin failures++; $display("FAIL b2b_final: got %0d, required 3000", SET_POS_PD); end
    drain();
  endtask

  task automatic test_enable_drop();
    send(400, 1'b1);
    send(401, 1'b1);
    send(402, 1'b1);
    repeat (3) tick();
    checks++;
    if (SET_POS_PD !== 32'd4000) begin failures++; $display("FAIL drop_second: got %0d, required 4000", SET_POS_PD); end
    set_enable(1'b0);
    tick();
    checks += 2;
    if (SET_POS_PD !== 32'(HOME_POS)) begin failures++; $display("FAIL drop_home: got %0d, required %0d", SET_POS_PD, HOME_POS); end
    if (SET_POS_VALID !== 1'b1) begin failures++; $display("FAIL drop_pulse: got %b, required 1", SET_POS_VALID); end
    repeat (5) tick();
    checks += 2;
    if (TRACKING !== 1'b0) begin failures++; $display("FAIL drop_tracking: got %b, required 0", TRACKING); end
    if (TIMED_OUT !== 1'b0) begin failures++; $display("FAIL drop_flag: got %b, required 0", TIMED_OUT); end
    drain();
  endtask

  task automatic test_reset_midstream();
    set_enable(1'b1);
    send(400, 1'b1);
    send(401, 1'b1);
    tick();
    #2;
    resetn = 1'b0;
    q.delete();
    mon_last  = HOME_POS;
    mdl_pos   = HOME_POS;
    mdl_empty = 1'b1;
    #1;
    checks += 4;
    if (SET_POS_PD !== 32'(HOME_POS)) begin failures++; $display("FAIL rst_mid_pos: got %0d, required %0d", SET_POS_PD, HOME_POS); end
    if (SET_POS_VALID !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b, required 0", SET_POS_VALID); end
    if (TRACKING !== 1'b0) begin failures++; $display("FAIL rst_mid_tracking: got %b, required 0", TRACKING); end
    if (TIMED_OUT !== 1'b0) begin failures++; $display("FAIL rst_mid_flag: got %b, required 0", TIMED_OUT); end
    repeat (3) tick();
    resetn = 1'b1;
    repeat (10) tick();
    checks++;
    if (TRACKING !== 1'b0) begin failures++; $display("FAIL rst_post_tracking: got %b, required 0", TRACKING); end
    send(400, 1'b1);
    drain();
    checks++;
    if (SET_POS_PD !== 32'd1500) begin failures++; $display("FAIL rst_post_refill: got %0d, required 1500", SET_POS_PD); end
  endtask

  initial begin
    tick();
    test_reset();
    test_track_step();
    test_averaging();
    test_clamp();
    test_watchdog();
    test_back_to_back();
    test_enable_drop();
    test_reset_midstream();
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
